// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/ready handshake to instruction
// memory and feeds the IF/ID register, inserting bubbles and flush pulses as needed.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instruction,
    output logic [31:0] PCplus4,
    output logic        instr_valid,
    output logic        IF_Flush
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pcplus4_reg, pcplus4_next;
    logic        valid_reg, valid_next;
    logic        flush_reg, flush_next;
    logic        req_reg, req_next;
    logic [31:0] hold_buf_reg, hold_buf_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;

    logic [31:0] target_aligned;
    logic [31:0] pc_plus4;

    assign target_aligned = branch_target & 32'hFFFF_FFFC;
    assign pc_plus4       = pc_reg + 32'd4;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        instr_next       = instr_reg;
        pcplus4_next     = pcplus4_reg;
        valid_next       = valid_reg;
        flush_next       = 1'b0;
        hold_buf_next    = hold_buf_reg;
        redirect_pc_next = redirect_pc_reg;

        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
                if (branch_taken) begin
                    pc_next    = target_aligned;
                    flush_next = 1'b1;
                    instr_next = 32'h0;
                    valid_next = 1'b0;
                end
            end
            S_FETCH: begin
                if (branch_taken) begin
                    flush_next = 1'b1;
                    instr_next = 32'h0;
                    valid_next = 1'b0;
                    if (imem_ready) begin
                        pc_next = target_aligned;
                    end else begin
                        // The outstanding request must complete at the old address first.
                        redirect_pc_next = target_aligned;
                        state_next       = S_DRAIN;
                    end
                end else if (imem_ready) begin
                    if (stall) begin
                        hold_buf_next = imem_rdata;
                        state_next    = S_HOLD;
                    end else begin
                        instr_next   = imem_rdata;
                        pcplus4_next = pc_plus4;
                        valid_next   = 1'b1;
                        pc_next      = pc_plus4;
                    end
                end else if (!stall) begin
                    instr_next = 32'h0;
                    valid_next = 1'b0;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    pc_next    = target_aligned;
                    flush_next = 1'b1;
                    instr_next = 32'h0;
                    valid_next = 1'b0;
                    state_next = S_FETCH;
                end else if (!stall) begin
                    instr_next   = hold_buf_reg;
                    pcplus4_next = pc_plus4;
                    valid_next   = 1'b1;
                    pc_next      = pc_plus4;
                    state_next   = S_FETCH;
                end
            end
            S_DRAIN: begin
                instr_next = 32'h0;
                valid_next = 1'b0;
                if (branch_taken) begin
                    redirect_pc_next = target_aligned;
                    flush_next       = 1'b1;
                end
                if (imem_ready) begin
                    pc_next    = branch_taken ? target_aligned : redirect_pc_reg;
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase

        req_next = (state_next == S_FETCH) || (state_next == S_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            pc_reg          <= RESET_PC;
            instr_reg       <= 32'h0;
            pcplus4_reg     <= 32'h0;
            valid_reg       <= 1'b0;
            flush_reg       <= 1'b0;
            req_reg         <= 1'b0;
            hold_buf_reg    <= 32'h0;
            redirect_pc_reg <= 32'h0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            instr_reg       <= instr_next;
            pcplus4_reg     <= pcplus4_next;
            valid_reg       <= valid_next;
            flush_reg       <= flush_next;
            req_reg         <= req_next;
            hold_buf_reg    <= hold_buf_next;
            redirect_pc_reg <= redirect_pc_next;
        end
    end

    assign imem_req    = req_reg;
    assign imem_addr   = pc_reg;
    assign instruction = instr_reg;
    assign PCplus4     = pcplus4_reg;
    assign instr_valid = valid_reg;
    assign IF_Flush    = flush_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: two instances cover the 0x100 and wrap-around reset PCs.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, imem_ready, stall, branch_taken;
    logic [31:0] imem_rdata, branch_target;
    logic        imem_req, instr_valid, IF_Flush;
    logic [31:0] imem_addr, instruction, PCplus4;

    logic        rst_n_b, imem_ready_b;
    logic [31:0] imem_rdata_b;
    logic        imem_req_b, instr_valid_b, IF_Flush_b;
    logic [31:0] imem_addr_b, instruction_b, PCplus4_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instruction(instruction), .PCplus4(PCplus4), .instr_valid(instr_valid),
        .IF_Flush(IF_Flush)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n_b), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_ready(imem_ready_b), .imem_rdata(imem_rdata_b), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .instruction(instruction_b), .PCplus4(PCplus4_b), .instr_valid(instr_valid_b),
        .IF_Flush(IF_Flush_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
        $display("[TB] %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic check_out(input string tag, input logic req, input logic [31:0] addr,
                             input logic [31:0] instr, input logic [31:0] p4,
                             input logic vld, input logic fl);
        check({tag, ".req"},   imem_req,    req);
        check({tag, ".addr"},  imem_addr,   addr);
        check({tag, ".instr"}, instruction, instr);
        check({tag, ".pc4"},   PCplus4,     p4);
        check({tag, ".valid"}, instr_valid, vld);
        check({tag, ".flush"}, IF_Flush,    fl);
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        imem_rdata = 32'h0; branch_target = 32'h0;
        rst_n_b = 1'b0; imem_ready_b = 1'b0; imem_rdata_b = 32'h0;

        // Reset state
        step();
        check_out("reset", 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);

        // Test 1: streaming fetch A, B, C
        rst_n = 1'b1; imem_ready = 1'b1;
        step();
        check_out("idle2fetch", 1'b1, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        imem_rdata = 32'hAAAA_0001;
        step();
        check_out("fetchA", 1'b1, 32'h104, 32'hAAAA_0001, 32'h104, 1'b1, 1'b0);

        // Test 2: stall for 3 cycles as B returns
        imem_rdata = 32'hBBBB_0002; stall = 1'b1;
        step();
        check_out("stall1", 1'b0, 32'h104, 32'hAAAA_0001, 32'h104, 1'b1, 1'b0);
        imem_rdata = 32'hDEAD_BEEF;
        step();
        check_out("stall2", 1'b0, 32'h104, 32'hAAAA_0001, 32'h104, 1'b1, 1'b0);
        step();
        check_out("stall3", 1'b0, 32'h104, 32'hAAAA_0001, 32'h104, 1'b1, 1'b0);
        stall = 1'b0;
        step();
        check_out("releaseB", 1'b1, 32'h108, 32'hBBBB_0002, 32'h108, 1'b1, 1'b0);
        imem_rdata = 32'hCCCC_0003;
        step();
        check_out("fetchC", 1'b1, 32'h10C, 32'hCCCC_0003, 32'h10C, 1'b1, 1'b0);

        // Test 3: branch with ready=1, misaligned target
        branch_taken = 1'b1; branch_target = 32'h0000_2003; imem_rdata = 32'h1111_1111;
        step();
        check_out("br_rdy", 1'b1, 32'h2000, 32'h0, 32'h10C, 1'b0, 1'b1);
        branch_taken = 1'b0; imem_rdata = 32'hEEEE_0005;
        step();
        check_out("br_tgt", 1'b1, 32'h2004, 32'hEEEE_0005, 32'h2004, 1'b1, 1'b0);

        // Test 4: branch while ready=0, then 3 more wait cycles
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_3000;
        step();
        check_out("drain0", 1'b1, 32'h2004, 32'h0, 32'h2004, 1'b0, 1'b1);
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("drainw", 1'b1, 32'h2004, 32'h0, 32'h2004, 1'b0, 1'b0);
        end
        imem_ready = 1'b1; imem_rdata = 32'h2222_2222;
        step();
        check_out("drained", 1'b1, 32'h3000, 32'h0, 32'h2004, 1'b0, 1'b0);
        imem_rdata = 32'h6666_0006;
        step();
        check_out("fetchTgt", 1'b1, 32'h3004, 32'h6666_0006, 32'h3004, 1'b1, 1'b0);

        // Bubble: ready low without stall
        imem_ready = 1'b0;
        step();
        check_out("bubble", 1'b1, 32'h3004, 32'h0, 32'h3004, 1'b0, 1'b0);

        // Second branch in DRAIN re-pulses flush, then reset mid-drain
        branch_taken = 1'b1; branch_target = 32'h0000_4000;
        step();
        check_out("drainB1", 1'b1, 32'h3004, 32'h0, 32'h3004, 1'b0, 1'b1);
        branch_target = 32'h0000_5000;
        step();
        check_out("drainB2", 1'b1, 32'h3004, 32'h0, 32'h3004, 1'b0, 1'b1);
        branch_taken = 1'b0;
        step();
        check_out("drainB3", 1'b1, 32'h3004, 32'h0, 32'h3004, 1'b0, 1'b0);

        // Test 6: reset during DRAIN
        rst_n = 1'b0;
        step();
        check_out("rstDrain", 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h7777_0007;
        step();
        check_out("rstIdle", 1'b1, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        check_out("rstFetch", 1'b1, 32'h104, 32'h7777_0007, 32'h104, 1'b1, 1'b0);

        // Test 5: PC wrap-around on the second instance
        rst_n_b = 1'b1; imem_ready_b = 1'b1; imem_rdata_b = 32'h8888_0008;
        step();
        check("wrap.addr0", imem_addr_b, 32'hFFFF_FFFC);
        check("wrap.req0",  imem_req_b,  32'h1);
        step();
        check("wrap.instr", instruction_b, 32'h8888_0008);
        check("wrap.pc4",   PCplus4_b,     32'h0);
        check("wrap.addr1", imem_addr_b,   32'h0);
        check("wrap.valid", instr_valid_b, 32'h1);
        check("wrap.flush", IF_Flush_b,    32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
